seg7_scan_ctrl: RTL

- Time-multiplexing scan controller for the Basys3 4-digit common-anode 7-segment display.
- Takes four 7-bit active-low segment codes (e.g. the steering-direction glyph from the character selector) plus decimal points and enable mask.
- Drives one digit at a time, inserting a blanking gap between digits to suppress ghosting.
- New display contents are loaded through a req/ack handshake only at frame boundaries, so a frame never mixes old and new characters.

---
 rtl/seg7_scan_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller with inter-digit blanking
// and frame-synchronous shadow loading through a req/ack handshake.
module seg7_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W = $clog2(((DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] char_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        frame_start,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [27:0]       r_char, w_char_nxt;
  logic [3:0]        r_dp_sh, w_dp_nxt;
  logic [3:0]        r_en, w_en_nxt;
  logic              w_boundary, w_load;
  logic [6:0]        w_seg_nxt;
  logic              w_dp_out_nxt;
  logic [3:0]        w_an_nxt;

  function automatic logic [6:0] sel_char(input logic [27:0] chars, input logic [1:0] idx);
    case (idx)
      2'd0:    sel_char = chars[6:0];
      2'd1:    sel_char = chars[13:7];
      2'd2:    sel_char = chars[20:14];
      default: sel_char = chars[27:21];
    endcase
  endfunction

  // Next-state: BLANK/DRIVE sequencing, cycle counter and digit index.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_boundary  = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == LP_BLANK_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_BLANK;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == LP_DIGIT_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
          w_boundary  = (r_idx == 2'd3);
        end else begin
          w_state_nxt = ST_DRIVE;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // Shadow contents change only on a frame boundary with a pending request.
  always_comb begin
    w_load     = w_boundary & upd_req;
    w_char_nxt = r_char;
    w_dp_nxt   = r_dp_sh;
    w_en_nxt   = r_en;
    if (w_load) begin
      w_char_nxt = char_in;
      w_dp_nxt   = dp_in;
      w_en_nxt   = digit_en;
    end else begin
      w_char_nxt = r_char;
    end
  end

  // Output values for the upcoming cycle, derived from next state so outputs stay registered.
  always_comb begin
    w_seg_nxt    = 7'b1111111;
    w_dp_out_nxt = 1'b1;
    w_an_nxt     = 4'b1111;
    if (w_state_nxt == ST_DRIVE) begin
      w_seg_nxt = sel_char(w_char_nxt, w_idx_nxt);
      if (w_en_nxt[w_idx_nxt]) begin
        w_an_nxt     = ~(4'b0001 << w_idx_nxt);
        w_dp_out_nxt = w_dp_nxt[w_idx_nxt];
      end else begin
        w_an_nxt     = 4'b1111;
        w_dp_out_nxt = 1'b1;
      end
    end else begin
      w_seg_nxt = 7'b1111111;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_BLANK;
      r_idx       <= 2'd0;
      r_cnt       <= '0;
      r_char      <= {4{7'b1111111}};
      r_dp_sh     <= 4'b1111;
      r_en        <= 4'b0000;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      an          <= 4'b1111;
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_char      <= w_char_nxt;
      r_dp_sh     <= w_dp_nxt;
      r_en        <= w_en_nxt;
      seg         <= w_seg_nxt;
      dp          <= w_dp_out_nxt;
      an          <= w_an_nxt;
      upd_ack     <= w_load;
      frame_start <= w_boundary;
    end
  end

endmodule
